ssio_idelay_cal: RTL
====================

Name: ssio_idelay_cal

Overview:
- Sweeps the input delay tap of a source-synchronous DDR receive path and locates the data eye using a known training pattern from the link partner.
- Programs the tap at the centre of the widest passing window.
- Sits in the RX clock domain, between the DDR input capture block (consumes its q1/q2 outputs) and the per-lane delay element (drives its tap value and load strobe).
- Typical use: RGMII RX alignment at link-up.

Parameters:
- DATA_WIDTH, 4: data bits per edge, excluding control.
- TAP_W, 5: tap value width.
- TAP_MAX, 31: last tap swept; sweep covers 0..TAP_MAX.
- DEFAULT_TAP, 0: tap used at reset and on calibration failure.
- SETTLE_CYCLES, 16: cycles ignored after each tap load.
- SAMPLE_CYCLES, 1024: observation window per tap.
- MIN_GOOD, 64: qualifying samples a tap needs to pass.
- MIN_EYE, 4: minimum passing run length for success.
- PATTERN, 4'h5: expected data on both edges while qualified.

Ports:
- clk, input, 1: RX logic clock (DDR capture output clock).
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle request to begin calibration.
- rx_d1, input, DATA_WIDTH: rising-edge data from DDR capture.
- rx_d2, input, DATA_WIDTH: falling-edge data.
- rx_ctl1, input, 1: rising-edge control.
- rx_ctl2, input, 1: falling-edge control.
- tap_value, output, TAP_W: tap presented to the delay element.
- tap_load, output, 1: one-cycle strobe; delay element latches tap_value.
- busy, output, 1: calibration in progress.
- done, output, 1: calibration finished; held until next start.
- fail, output, 1: valid with done; no eye of MIN_EYE or more found.
- eye_start, output, TAP_W: first tap of the selected run.
- eye_len, output, TAP_W+1: length of the selected run.

Behaviour:
- Reset: FSM to IDLE. tap_value=DEFAULT_TAP, tap_load=0, busy=0, done=0, fail=0, eye_start=0, eye_len=0, all counters 0. The delay element resets to DEFAULT_TAP on the same reset.
- FSM states: IDLE, LOAD, SETTLE, SAMPLE, EVAL, APPLY, DONE.
- IDLE/DONE + start: clear done, fail, run trackers and best trackers; tap=0; go to LOAD; busy=1.
- LOAD: drive tap_value=tap and pulse tap_load for 1 cycle; go to SETTLE.
- SETTLE: count SETTLE_CYCLES, ignore inputs; go to SAMPLE.
- SAMPLE: run for SAMPLE_CYCLES cycles.
  - Qualifying sample: rx_ctl1 & rx_ctl2.
  - Good count (saturating) increments when qualifying and rx_d1==PATTERN and rx_d2==PATTERN.
  - Error flag sets when qualifying and either nibble differs from PATTERN.
  - Go to EVAL.
- EVAL (1 cycle): pass = (good >= MIN_GOOD) & ~error.
  - On pass: if cur_len==0, cur_start=tap; cur_len+=1; if new cur_len > best_len (strictly), best_start/best_len take cur values. First of equal-length runs wins.
  - On fail: cur_len=0.
  - Clear good and error.
  - If tap==TAP_MAX, go to APPLY; else tap+=1 and go to LOAD.
- APPLY:
  - If best_len >= MIN_EYE: tap_value = best_start + ((best_len-1)>>1) (floor centre), fail=0.
  - Else: tap_value = DEFAULT_TAP, fail=1.
  - Pulse tap_load; latch eye_start/eye_len from best; go to DONE.
- DONE: busy=0, done=1.
- Latency: TAP_MAX+1 sweeps of (2+SETTLE_CYCLES+SAMPLE_CYCLES) cycles, plus 1 APPLY cycle, from start to done.
- start while busy is ignored.
- A run reaching TAP_MAX closes naturally; it is included in the best-run comparison at EVAL.
- Reset mid-operation aborts immediately to reset values. No partial result is applied.
- Counter widths: sample counter clog2(SAMPLE_CYCLES+1); good counter clog2(MIN_GOOD+1), saturating at MIN_GOOD.

Optional Feature:
- SSIO_IDELAY_CAL_MAP_EN defined: adds output pass_map[TAP_MAX:0]. Bit tap is written with the pass result at each EVAL, cleared at start, reset to 0, and holds after done.
- Undefined: port and register are absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - FSM state enum (7 states).
  - Localparams for counter widths.
  - Pass-evaluation helper constant PATTERN default.
- One natural sub-module: ssio_idelay_cal_window. It covers the SAMPLE/EVAL qualifying counter, error flag and pass output.
- The run/best tracker and FSM stay in the top.

Test Plan:
- Pattern clean only at taps 10..17, error elsewhere -> eye_start=10, eye_len=8, final tap_value=13, fail=0, done=1, one tap_load per tap plus one in APPLY.
- rx_ctl held low throughout -> every tap fails; fail=1, eye_len=0, final tap_value=DEFAULT_TAP.
- Passing runs 2..5 and 20..23 -> first run kept; eye_start=2, tap_value=3.
- Pass 10..17 except one corrupted sample (rx_d2=4'h4) at tap 12 -> best run 13..17, eye_len=5, tap_value=15.
- Pass 28..31 -> run closed at sweep end; eye_start=28, eye_len=4, tap_value=29.
- start re-pulsed during SAMPLE -> ignored. Then rst_n low mid-SAMPLE -> all outputs at reset values. Then fresh start -> completes with the expected result.

Source files
------------

// File: rtl/ssio_idelay_cal_pkg.sv
// Shared types and defaults for the source-synchronous input delay calibrator.
// Holds the FSM state encoding, default timing constants and the counter width helper.
package ssio_idelay_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_APPLY,
        ST_DONE
    } cal_state_e;

    localparam int unsigned DEF_SETTLE_CYCLES = 16;
    localparam int unsigned DEF_SAMPLE_CYCLES = 1024;
    localparam int unsigned DEF_MIN_GOOD      = 64;
    localparam logic [3:0]  DEF_PATTERN       = 4'h5;

    // Bits needed to hold 0..max_count inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/ssio_idelay_cal_window.sv
// Per-tap observation window: counts clean training samples and flags any corrupted one.
// pass is valid in the cycle after the last sample; clear_i restarts the window.
module ssio_idelay_cal_window
    import ssio_idelay_cal_pkg::*;
#(
    parameter int unsigned               DATA_WIDTH = 4,
    parameter int unsigned               MIN_GOOD   = DEF_MIN_GOOD,
    parameter logic [DATA_WIDTH-1:0]     PATTERN    = DEF_PATTERN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_en_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] rx_d1_i,
    input  logic [DATA_WIDTH-1:0] rx_d2_i,
    input  logic                  rx_ctl1_i,
    input  logic                  rx_ctl2_i,
    output logic                  pass_o
);

    localparam int unsigned GOOD_W = cnt_width(MIN_GOOD);
    localparam logic [GOOD_W-1:0] GOOD_SAT = GOOD_W'(MIN_GOOD);

    logic [GOOD_W-1:0] good_q, good_d;
    logic              err_q, err_d;
    logic              qualify, match;

    assign qualify = rx_ctl1_i & rx_ctl2_i;
    assign match   = (rx_d1_i == PATTERN) && (rx_d2_i == PATTERN);

    // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
    always_comb begin
        good_d = good_q;
        err_d  = err_q;
        if (clear_i) begin
            good_d = '0;
            err_d  = 1'b0;
        end else if (sample_en_i && qualify) begin
            if (!match)
                err_d = 1'b1;
            else if (good_q != GOOD_SAT)
                good_d = good_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_q <= '0;
            err_q  <= 1'b0;
        end else begin
            good_q <= good_d;
            err_q  <= err_d;
        end
    end

    assign pass_o = (good_q >= GOOD_SAT) && !err_q;

endmodule

// File: rtl/ssio_idelay_cal.sv
// Sweeps the RX input delay tap, finds the widest clean run and programs its floor centre.
// Optional SSIO_IDELAY_CAL_MAP_EN adds a per-tap pass_map output.
module ssio_idelay_cal
    import ssio_idelay_cal_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH    = 4,
    parameter int unsigned           TAP_W         = 5,
    parameter int unsigned           TAP_MAX       = 31,
    parameter int unsigned           DEFAULT_TAP   = 0,
    parameter int unsigned           SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned           SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int unsigned           MIN_GOOD      = DEF_MIN_GOOD,
    parameter int unsigned           MIN_EYE       = 4,
    parameter logic [DATA_WIDTH-1:0] PATTERN       = DEF_PATTERN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] rx_d1,
    input  logic [DATA_WIDTH-1:0] rx_d2,
    input  logic                  rx_ctl1,
    input  logic                  rx_ctl2,
    output logic [TAP_W-1:0]      tap_value,
    output logic                  tap_load,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
`ifdef SSIO_IDELAY_CAL_MAP_EN
    output logic [TAP_MAX:0]      pass_map,
`endif
    output logic [TAP_W-1:0]      eye_start,
    output logic [TAP_W:0]        eye_len
);

    localparam int unsigned CNT_W = cnt_width(SAMPLE_CYCLES > SETTLE_CYCLES ?
                                              SAMPLE_CYCLES : SETTLE_CYCLES);
    localparam int unsigned LEN_W = TAP_W + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(TAP_MAX);
    localparam logic [TAP_W-1:0] TAP_DEF     = TAP_W'(DEFAULT_TAP);

    cal_state_e        state_q;
    logic [TAP_W-1:0]  tap_q, tap_value_q, cur_start_q, best_start_q, eye_start_q;
    logic [LEN_W-1:0]  cur_len_q, best_len_q, eye_len_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              tap_load_q, busy_q, done_q, fail_q;
    logic              win_pass;
    logic [TAP_W-1:0]  run_start, centre_tap;
    logic [LEN_W-1:0]  run_len, half_len;
`ifdef SSIO_IDELAY_CAL_MAP_EN
    logic [TAP_MAX:0]  pass_map_q;
`endif

    ssio_idelay_cal_window #(
        .DATA_WIDTH (DATA_WIDTH),
        .MIN_GOOD   (MIN_GOOD),
        .PATTERN    (PATTERN)
    ) u_window (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_en_i (state_q == ST_SAMPLE),
        .clear_i     (state_q == ST_EVAL),
        .rx_d1_i     (rx_d1),
        .rx_d2_i     (rx_d2),
        .rx_ctl1_i   (rx_ctl1),
        .rx_ctl2_i   (rx_ctl2),
        .pass_o      (win_pass)
    );

    // A passing tap either opens a new run or extends the current one.
    always_comb begin
        run_start  = (cur_len_q == '0) ? tap_q : cur_start_q;
        run_len    = cur_len_q + 1'b1;
        half_len   = (best_len_q - 1'b1) >> 1;
        centre_tap = best_start_q + half_len[TAP_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tap_q        <= '0;
            cnt_q        <= '0;
            tap_value_q  <= TAP_DEF;
            tap_load_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            eye_start_q  <= '0;
            eye_len_q    <= '0;
`ifdef SSIO_IDELAY_CAL_MAP_EN
            pass_map_q   <= '0;
`endif
        end else begin
            tap_load_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q      <= ST_LOAD;
                        tap_q        <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        fail_q       <= 1'b0;
                        cur_start_q  <= '0;
                        cur_len_q    <= '0;
                        best_start_q <= '0;
                        best_len_q   <= '0;
`ifdef SSIO_IDELAY_CAL_MAP_EN
                        pass_map_q   <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    tap_value_q <= tap_q;
                    tap_load_q  <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    cnt_q <= (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == SETTLE_LAST)
                        state_q <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    cnt_q <= (cnt_q == SAMPLE_LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == SAMPLE_LAST)
                        state_q <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (win_pass) begin
                        cur_start_q <= run_start;
                        cur_len_q   <= run_len;
                        // Strict compare keeps the earliest of equal-length runs.
                        if (run_len > best_len_q) begin
                            best_start_q <= run_start;
                            best_len_q   <= run_len;
                        end
                    end else begin
                        cur_len_q <= '0;
                    end
`ifdef SSIO_IDELAY_CAL_MAP_EN
                    pass_map_q[tap_q] <= win_pass;
`endif
                    if (tap_q == TAP_LAST) begin
                        state_q <= ST_APPLY;
                    end else begin
                        tap_q   <= tap_q + 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_APPLY: begin
                    if (best_len_q >= LEN_W'(MIN_EYE)) begin
                        tap_value_q <= centre_tap;
                        fail_q      <= 1'b0;
                    end else begin
                        tap_value_q <= TAP_DEF;
                        fail_q      <= 1'b1;
                    end
                    tap_load_q  <= 1'b1;
                    eye_start_q <= best_start_q;
                    eye_len_q   <= best_len_q;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tap_value = tap_value_q;
    assign tap_load  = tap_load_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign eye_start = eye_start_q;
    assign eye_len   = eye_len_q;
`ifdef SSIO_IDELAY_CAL_MAP_EN
    assign pass_map  = pass_map_q;
`endif

endmodule
